// File: rtl/clk_div_sched.sv
// Run/stop and ratio-reconfiguration controller for the divide-by-N clock generator.
// Ratio changes, starts and stops all take effect on period boundaries; outputs are registered.
module clk_div_sched #(
   parameter int unsigned W       = 8,
   parameter int unsigned DEF_DIV = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         div_clk,
   output logic         div_tick,
   output logic         busy,
   output logic [W-1:0] cur_div
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   cnt, cnt_n;
   logic [W-1:0]   cur_div_n;
   logic [W-1:0]   pend_div, pend_div_n;
   logic           pend_vld, pend_vld_n;
   logic           xfer, ratio_ok, boundary, active_n;
   logic           cfg_err_n, div_clk_n, div_tick_n, busy_n, cfg_ready_n;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         cur_div   <= W'(DEF_DIV);
         pend_div  <= '0;
         pend_vld  <= 1'b0;
         cfg_err   <= 1'b0;
         div_clk   <= 1'b0;
         div_tick  <= 1'b0;
         busy      <= 1'b0;
         cfg_ready <= 1'b1;
      end else begin
         cnt       <= cnt_n;
         cur_div   <= cur_div_n;
         pend_div  <= pend_div_n;
         pend_vld  <= pend_vld_n;
         cfg_err   <= cfg_err_n;
         div_clk   <= div_clk_n;
         div_tick  <= div_tick_n;
         busy      <= busy_n;
         cfg_ready <= cfg_ready_n;
      end
   end

   // Next-state, counter, ratio/pending update and next output values
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cur_div_n  = cur_div;
      pend_div_n = pend_div;
      pend_vld_n = pend_vld;

      xfer      = cfg_valid && cfg_ready;
      ratio_ok  = (cfg_div >= W'(2));
      cfg_err_n = xfer && !ratio_ok;
      boundary  = (state != IDLE) && (cnt == (cur_div - W'(1)));

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (xfer && ratio_ok) begin
               cur_div_n = cfg_div;
            end
            if (en) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (!en) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (en) begin
               state_n = RUN;
            end else if (boundary) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Counting and pending-ratio handling shared by RUN and DRAIN
      if (state != IDLE) begin
         cnt_n = boundary ? '0 : (cnt + W'(1));
         if (boundary && pend_vld) begin
            cur_div_n  = pend_div;
            pend_vld_n = 1'b0;
         end
         // Only reachable while nothing is pending, so never collides with the apply above
         if (xfer && ratio_ok) begin
            pend_vld_n = 1'b1;
            pend_div_n = cfg_div;
         end
      end

      active_n    = (state_n != IDLE);
      div_clk_n   = active_n && (cnt_n < (cur_div_n >> 1));
      div_tick_n  = active_n && (cnt_n == '0);
      busy_n      = active_n;
      cfg_ready_n = !pend_vld_n;
   end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios followed by random traffic,
// every cycle compared against a period/position reference model.
module tb_clk_div_sched;

   localparam int unsigned W       = 8;
   localparam int unsigned DEF_DIV = 5;

   logic         clk;
   logic         rst;
   logic         en;
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         cfg_err;
   logic         div_clk;
   logic         div_tick;
   logic         busy;
   logic [W-1:0] cur_div;

   int compared;
   int mismatched;

   // Reference model: generating flag, position within period, ratio, pending ratio (-1 = none)
   bit m_on;
   bit m_stop;
   bit m_err;
   int m_pos;
   int m_ratio;
   int m_pend;

   clk_div_sched #(.W(W), .DEF_DIV(DEF_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .div_clk   (div_clk),
      .div_tick  (div_tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge();
      bit xfer;
      int d;
      bit had_pend;
      d = int'(cfg_div);
      if (rst) begin
         m_on = 0; m_stop = 0; m_err = 0; m_pos = 0; m_ratio = DEF_DIV; m_pend = -1;
         return;
      end
      xfer  = cfg_valid && (m_pend < 0);
      m_err = xfer && (d < 2);
      if (!m_on) begin
         if (xfer && d >= 2) m_ratio = d;
         if (en) begin
            m_on = 1; m_pos = 0;
         end
         m_stop = 0;
      end else begin
         had_pend = (m_pend >= 0);
         if (m_pos == m_ratio - 1) begin
            m_pos = 0;
            if (had_pend) begin
               m_ratio = m_pend; m_pend = -1;
            end
            if (m_stop && !en) m_on = 0;
         end else begin
            m_pos = m_pos + 1;
         end
         if (xfer && d >= 2) m_pend = d;
         m_stop = !en;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("div_clk",   32'(div_clk),   32'(m_on && (m_pos < m_ratio / 2)));
      chk("div_tick",  32'(div_tick),  32'(m_on && (m_pos == 0)));
      chk("busy",      32'(busy),      32'(m_on));
      chk("cur_div",   32'(cur_div),   32'(m_ratio));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_pend < 0));
      chk("cfg_err",   32'(cfg_err),   32'(m_err));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic offer(input int d);
      cfg_valid = 1'b1;
      cfg_div   = W'(d);
      step();
      cfg_valid = 1'b0;
   endtask

   // Advance until the current cycle sits at position p of a period with nothing pending
   task automatic wait_pos(input int p);
      bit found;
      found = (m_on && m_pos == p && m_pend < 0);
      for (int i = 0; i < 600 && !found; i++) begin
         step();
         found = (m_on && m_pos == p && m_pend < 0);
      end
      compared++;
      assert (found) else begin
         mismatched++;
         $error("FAIL wait_pos observed=timeout expected=pos %0d", p);
      end
   endtask

   initial begin
      int r;
      rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
      run(2);
      rst = 1'b0;
      run(3);

      // Start with the default ratio
      en = 1'b1;
      run(16);

      // Ratio 8 offered mid-period
      wait_pos(1);
      offer(8);
      run(20);

      // Back to 5, then offer 3 exactly on the boundary cycle
      wait_pos(1);
      offer(5);
      run(12);
      wait_pos(4);
      offer(3);
      run(16);

      // Stop mid-period, then restart and re-raise during drain
      wait_pos(1);
      offer(5);
      run(8);
      wait_pos(1);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(6);
      wait_pos(1);
      en = 1'b0;
      step();
      en = 1'b1;
      run(12);

      // Invalid ratios in IDLE and while running
      en = 1'b0;
      run(10);
      offer(1);
      offer(0);
      run(3);
      en = 1'b1;
      run(3);
      offer(1);
      offer(0);
      run(10);

      // Reset mid-run with a ratio pending
      wait_pos(1);
      offer(8);
      run(12);
      wait_pos(0);
      offer(4);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      en  = 1'b0;
      run(3);
      en = 1'b1;
      run(12);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) en = ~en;
         cfg_valid = ($urandom_range(0, 9) == 0);
         r = int'($urandom_range(0, 9));
         if (r < 2)      cfg_div = W'(r);
         else if (r < 8) cfg_div = W'($urandom_range(2, 10));
         else            cfg_div = W'($urandom_range(2, 40));
         rst = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0; cfg_valid = 1'b0;
      run(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
